// File: rtl/two_opt_metropolis.sv
// 2-opt move evaluator: fetches the four boundary cities and four edge lengths of a segment
// reversal, forms the tour delta and makes the Metropolis accept/reject decision.
module two_opt_metropolis #(
    parameter int unsigned CITY_NUM = 30,
    parameter int unsigned BASE_LOG = 4,
    parameter int unsigned POS_W    = 6,
    parameter int unsigned DIST_W   = 16,
    parameter int unsigned BETA_W   = 16,
    parameter int unsigned EXP_AW   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [BASE_LOG-1:0]        base_id,
    input  logic [POS_W-1:0]           K,
    input  logic [POS_W-1:0]           L,
    input  logic [31:0]                r_metropolis,
    input  logic [BETA_W-1:0]          beta,
    output logic [POS_W-1:0]           ord_addr,
    input  logic [POS_W-1:0]           ord_rdata,
    output logic [POS_W-1:0]           dist_a,
    output logic [POS_W-1:0]           dist_b,
    input  logic [DIST_W-1:0]          dist_rdata,
    output logic [EXP_AW-1:0]          exp_addr,
    input  logic [31:0]                exp_rdata,
    output logic                       busy,
    output logic                       done,
    output logic                       accept,
    output logic signed [DIST_W+1:0]   delta,
    output logic [BASE_LOG-1:0]        base_id_o
);

    localparam logic [POS_W-1:0]  POS_ONE   = POS_W'(1);
    localparam logic [POS_W-1:0]  CITY_LAST = POS_W'(CITY_NUM);
    localparam int unsigned       PROD_W    = DIST_W + 1 + BETA_W;
    localparam logic [EXP_AW-1:0] EXP_MAX   = '1;

    typedef enum logic [2:0] {
        StIdle,
        StOrd,
        StDist,
        StExp,
        StFin
    } state_e;

    state_e state_q, state_d;

    logic [3:0]              cnt_q;
    logic [POS_W-1:0]        k_q, l_q;
    logic [31:0]             r_q;
    logic [BETA_W-1:0]       beta_q;
    logic [POS_W-1:0]        a_q, b_q, c_q, d_q;
    logic [DIST_W-1:0]       dab_q, dcd_q, dac_q;
    logic signed [DIST_W+1:0] delta_q;

    logic                     launch;
    logic                     legal;
    logic signed [DIST_W+1:0] delta_raw;
    logic signed [DIST_W+1:0] delta_d;
    logic [PROD_W-1:0]        prod;
    logic [PROD_W-9:0]        scaled;
    logic [EXP_AW-1:0]        exp_addr_d;
    logic                     accept_d;

    // ---------------------------------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        launch  = 1'b0;
        unique case (state_q)
            StIdle, StFin: begin
                if (start) begin
                    launch  = 1'b1;
                    state_d = StOrd;
                end else begin
                    state_d = StIdle;
                end
            end
            StOrd: begin
                busy = 1'b1;
                if (cnt_q == 4'd5) state_d = StDist;
            end
            StDist: begin
                busy = 1'b1;
                if (cnt_q == 4'd10) state_d = StExp;
            end
            StExp: begin
                busy = 1'b1;
                if (cnt_q == 4'd12) state_d = StFin;
            end
            default: state_d = StIdle;
        endcase
    end

    // ---------------------------------------------------------------------------------------
    // Delta and exp-table address; the last edge length is taken straight off the read port so
    // the address is registered in time for the cycle-11 lookup.
    // ---------------------------------------------------------------------------------------
    always_comb begin
        legal     = (k_q != '0) && (k_q < l_q) && (l_q <= CITY_LAST);
        delta_raw = $signed({2'b00, dac_q}) + $signed({2'b00, dist_rdata})
                  - $signed({2'b00, dab_q}) - $signed({2'b00, dcd_q});
        delta_d   = legal ? delta_raw : '0;

        prod      = {{BETA_W{1'b0}}, delta_d[DIST_W:0]} * {{(DIST_W + 1){1'b0}}, beta_q};
        scaled    = prod[PROD_W-1:8];
        exp_addr_d = '0;
        if (!delta_d[DIST_W+1] && (delta_d != '0)) begin
            if (|scaled[PROD_W-9:EXP_AW]) begin
                exp_addr_d = EXP_MAX;
            end else begin
                exp_addr_d = scaled[EXP_AW-1:0];
            end
        end

        accept_d = legal && (delta_q[DIST_W+1] || (delta_q == '0) || (r_q < exp_rdata));
    end

    // ---------------------------------------------------------------------------------------
    // Sequencer datapath: cnt_q is the cycle number within the move.
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            k_q       <= '0;
            l_q       <= '0;
            r_q       <= '0;
            beta_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            d_q       <= '0;
            dab_q     <= '0;
            dcd_q     <= '0;
            dac_q     <= '0;
            delta_q   <= '0;
            ord_addr  <= '0;
            dist_a    <= '0;
            dist_b    <= '0;
            exp_addr  <= '0;
            done      <= 1'b0;
            accept    <= 1'b0;
            delta     <= '0;
            base_id_o <= '0;
        end else begin
            done <= 1'b0;
            if (launch) begin
                cnt_q     <= 4'd1;
                k_q       <= K;
                l_q       <= L;
                r_q       <= r_metropolis;
                beta_q    <= beta;
                base_id_o <= base_id;
                ord_addr  <= K - POS_ONE;
            end else if (busy) begin
                cnt_q <= cnt_q + 4'd1;
                case (cnt_q)
                    4'd1: ord_addr <= k_q;
                    4'd2: begin
                        ord_addr <= l_q;
                        a_q      <= ord_rdata;
                    end
                    4'd3: begin
                        ord_addr <= l_q + POS_ONE;
                        b_q      <= ord_rdata;
                    end
                    4'd4: c_q <= ord_rdata;
                    4'd5: begin
                        d_q    <= ord_rdata;
                        dist_a <= a_q;
                        dist_b <= b_q;
                    end
                    4'd6: begin
                        dist_a <= c_q;
                        dist_b <= d_q;
                    end
                    4'd7: begin
                        dist_a <= a_q;
                        dist_b <= c_q;
                        dab_q  <= dist_rdata;
                    end
                    4'd8: begin
                        dist_a <= b_q;
                        dist_b <= d_q;
                        dcd_q  <= dist_rdata;
                    end
                    4'd9:  dac_q <= dist_rdata;
                    4'd10: begin
                        delta_q  <= delta_d;
                        exp_addr <= exp_addr_d;
                    end
                    4'd12: begin
                        accept <= accept_d;
                        delta  <= delta_q;
                        done   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
